// File: rtl/seg_display_scheduler.sv
// +--------------------------------------------------------------------------+
// | Module   : seg_display_scheduler                                         |
// | Purpose  : Peak-magnitude tracker and eight-digit display sequencer,     |
// |            decimal (double-dabble) or raw-hex readout per refresh tick.  |
// | Option   : SEG_LAMP_TEST_EN adds a lamp_test override input.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module seg_display_scheduler #(
    parameter int SAMPLE_W       = 16,
    parameter int REFRESH_CYCLES = 5000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic                mode,
`ifdef SEG_LAMP_TEST_EN
    input  logic                lamp_test,
`endif
    output logic [31:0]         digit_out,
    output logic [7:0]          digit_en,
    output logic                update_done,
    output logic                busy,
    output logic                overrun
);

    localparam int c_CNT_W      = $clog2(REFRESH_CYCLES);
    localparam int c_IT_W       = $clog2(SAMPLE_W);
    localparam int c_HEX_DIGITS = (SAMPLE_W + 3) / 4;
    localparam int c_DD_W       = SAMPLE_W + 32;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [c_IT_W-1:0]  c_IT_LAST  = c_IT_W'(SAMPLE_W - 1);
    localparam logic [7:0]         c_HEX_EN   = 8'((1 << c_HEX_DIGITS) - 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_CAPTURE = 2'd1;
    localparam logic [1:0] c_CONVERT = 2'd2;
    localparam logic [1:0] c_UPDATE  = 2'd3;

    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_IT_W-1:0]   r_iter;
    logic [SAMPLE_W-1:0] r_peak;
    logic [SAMPLE_W-1:0] r_last;
    logic [c_DD_W-1:0]   r_dd;
    logic [31:0]         r_digit;
    logic [7:0]          r_en;
    logic                r_update_done;
    logic                r_overrun;

    logic                w_tick;
    logic [SAMPLE_W-1:0] w_mag;
    logic [31:0]         w_bcd_adj;
    logic [c_DD_W-1:0]   w_dd_next;
    logic [31:0]         w_bcd_next;
    logic [7:0]          w_dec_en;

    assign w_tick = (r_cnt == c_CNT_LAST);
    assign w_mag  = sample_in[SAMPLE_W-1] ? (~sample_in + SAMPLE_W'(1)) : sample_in;

    // One double-dabble step: bias every BCD nibble >= 5 by 3, then shift {bcd, bin}.
    for (genvar k = 0; k < 8; k++) begin : g_adj
        assign w_bcd_adj[4*k +: 4] = (r_dd[SAMPLE_W + 4*k +: 4] >= 4'd5)
                                   ? r_dd[SAMPLE_W + 4*k +: 4] + 4'd3
                                   : r_dd[SAMPLE_W + 4*k +: 4];
    end

    assign w_dd_next  = {w_bcd_adj, r_dd[SAMPLE_W-1:0]} << 1;
    assign w_bcd_next = w_dd_next[SAMPLE_W +: 32];

    // Leading-zero blanking: digit k lit when it or any higher digit is nonzero.
    assign w_dec_en[0] = 1'b1;
    for (genvar k = 1; k < 8; k++) begin : g_en
        assign w_dec_en[k] = |w_bcd_next[31:4*k];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_cnt         <= '0;
            r_iter        <= '0;
            r_peak        <= '0;
            r_last        <= '0;
            r_dd          <= '0;
            r_digit       <= '0;
            r_en          <= 8'b0000_0001;
            r_update_done <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_cnt         <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + c_CNT_W'(1);
            r_update_done <= 1'b0;

            if (w_tick && (r_state != c_IDLE)) begin
                r_overrun <= 1'b1;
            end

            // A sample landing on the snapshot cycle belongs to the next interval.
            if (r_state == c_CAPTURE) begin
                r_peak <= sample_valid ? w_mag : '0;
            end else if (sample_valid && (w_mag > r_peak)) begin
                r_peak <= w_mag;
            end

            if (sample_valid) begin
                r_last <= sample_in;
            end

            case (r_state)
                c_IDLE: begin
                    if (w_tick) begin
                        r_state <= c_CAPTURE;
                    end
                end
                c_CAPTURE: begin
                    r_dd   <= {32'd0, r_peak};
                    r_iter <= '0;
                    if (mode) begin
                        r_digit       <= {{(32-SAMPLE_W){1'b0}}, r_last};
                        r_en          <= c_HEX_EN;
                        r_update_done <= 1'b1;
                        r_state       <= c_UPDATE;
                    end else begin
                        r_state <= c_CONVERT;
                    end
                end
                c_CONVERT: begin
                    r_dd   <= w_dd_next;
                    r_iter <= r_iter + c_IT_W'(1);
                    if (r_iter == c_IT_LAST) begin
                        r_digit       <= w_bcd_next;
                        r_en          <= w_dec_en;
                        r_update_done <= 1'b1;
                        r_state       <= c_UPDATE;
                    end
                end
                c_UPDATE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign update_done = r_update_done;
    assign busy        = (r_state != c_IDLE);
    assign overrun     = r_overrun;

`ifdef SEG_LAMP_TEST_EN
    assign digit_out = lamp_test ? 32'h8888_8888 : r_digit;
    assign digit_en  = lamp_test ? 8'hFF : r_en;
`else
    assign digit_out = r_digit;
    assign digit_en  = r_en;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seg_display_scheduler.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_seg_display_scheduler                                      |
// | Purpose  : Self-checking bench with a cycle-level behavioural model.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_seg_display_scheduler;

    localparam int W  = 16;
    localparam int R  = 100;
    localparam int R2 = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          reset2 = 1'b1;
    logic [W-1:0]  sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          mode = 1'b0;
    logic [W-1:0]  zero_sample = '0;
    logic          zero_bit = 1'b0;
`ifdef SEG_LAMP_TEST_EN
    logic          lamp_test = 1'b0;
`endif

    logic [31:0] digit_out, digit_out2;
    logic [7:0]  digit_en, digit_en2;
    logic        update_done, busy, overrun;
    logic        update_done2, busy2, overrun2;

    always #5 clk = ~clk;

    seg_display_scheduler #(.SAMPLE_W(W), .REFRESH_CYCLES(R)) u_dut (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .mode(mode),
`ifdef SEG_LAMP_TEST_EN
        .lamp_test(lamp_test),
`endif
        .digit_out(digit_out), .digit_en(digit_en), .update_done(update_done),
        .busy(busy), .overrun(overrun)
    );

    // Refresh period shorter than a conversion, idle inputs.
    seg_display_scheduler #(.SAMPLE_W(W), .REFRESH_CYCLES(R2)) u_dut2 (
        .clk(clk), .reset(reset2), .sample_in(zero_sample), .sample_valid(zero_bit),
        .mode(zero_bit),
`ifdef SEG_LAMP_TEST_EN
        .lamp_test(zero_bit),
`endif
        .digit_out(digit_out2), .digit_en(digit_en2), .update_done(update_done2),
        .busy(busy2), .overrun(overrun2)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state (per cycle)
    int          cyc = 0;
    int          m_cnt = 0, m_peak = 0, m_cap = -1, m_upd = -1;
    logic [W-1:0] m_last = '0;
    logic [31:0] m_shown = '0, m_pend = '0;
    logic [7:0]  m_shown_en = 8'h01, m_pend_en = 8'h01;
    logic        m_ovr = 1'b0;
    bit          chk_en = 1'b0;
    logic [31:0] e_d;
    logic [7:0]  e_e;
    logic        e_busy, e_done, m_tick;

    function automatic int mag_of(input logic [W-1:0] s);
        int v;
        v = $signed(s);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] dec_en(input int v);
        int n, x;
        n = 1;
        x = v / 10;
        while (x > 0) begin
            n++;
            x = x / 10;
        end
        return 8'((1 << n) - 1);
    endfunction

    always @(negedge clk) begin
        e_d    = m_shown;
        e_e    = m_shown_en;
`ifdef SEG_LAMP_TEST_EN
        if (lamp_test) begin
            e_d = 32'h8888_8888;
            e_e = 8'hFF;
        end
`endif
        e_busy = (cyc >= m_cap) && (cyc <= m_upd);
        e_done = (cyc == m_upd);
        if (chk_en) begin
            n_vec++;
            if ({digit_out, digit_en, update_done, busy, overrun} !== {e_d, e_e, e_done, e_busy, m_ovr}) begin
                n_err++;
                $display("FAIL cycle %0d: got dig=%h en=%h done=%b busy=%b ovr=%b, expected dig=%h en=%h done=%b busy=%b ovr=%b",
                         cyc, digit_out, digit_en, update_done, busy, overrun, e_d, e_e, e_done, e_busy, m_ovr);
            end
        end
        if (reset) begin
            m_cnt = 0; m_peak = 0; m_last = '0; m_cap = -1; m_upd = -1;
            m_shown = '0; m_shown_en = 8'h01; m_ovr = 1'b0; chk_en = 1'b1;
        end else begin
            m_tick = (m_cnt == R - 1);
            if (cyc == m_cap) begin
                if (mode) begin
                    m_pend = {16'h0, m_last}; m_pend_en = 8'h0F; m_upd = cyc + 1;
                end else begin
                    m_pend = to_bcd(m_peak); m_pend_en = dec_en(m_peak); m_upd = cyc + 1 + W;
                end
                m_peak = sample_valid ? mag_of(sample_in) : 0;
            end else if (sample_valid && (mag_of(sample_in) > m_peak)) begin
                m_peak = mag_of(sample_in);
            end
            if (sample_valid) m_last = sample_in;
            if (m_tick) begin
                if (!e_busy) begin
                    m_cap = cyc + 1;
                    m_upd = cyc + 1000;
                end else begin
                    m_ovr = 1'b1;
                end
            end
            if (cyc + 1 == m_upd) begin
                m_shown = m_pend;
                m_shown_en = m_pend_en;
            end
            m_cnt = (m_cnt == R - 1) ? 0 : m_cnt + 1;
        end
        cyc++;
    end

    // Second instance observer
    int rc2 = 0, first_ovr2 = -1, first_done2 = -1, done2 = 0;
    always @(negedge clk) begin
        if (reset2) begin
            rc2 = 0;
        end else begin
            if (overrun2 && first_ovr2 < 0) first_ovr2 = rc2;
            if (update_done2) begin
                if (first_done2 < 0) first_done2 = rc2;
                done2++;
            end
            rc2++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input int v);
        @(posedge clk); #1;
        sample_valid = 1'b1;
        sample_in    = W'(v);
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic run_interval(input bit wait_idle, input int exp_lat,
                                input logic [31:0] ed, input logic [7:0] ee, input string name);
        int n;
        if (wait_idle) begin
            n = 0;
            @(negedge clk);
            while (busy && n < 100) begin @(negedge clk); n++; end
        end
        n = 0;
        @(negedge clk);
        while (!busy && n < 300) begin @(negedge clk); n++; end
        if (!busy) begin
            chk({name, " capture timeout"}, 32'(busy), 32'd1);
            return;
        end
        n = 1;
        while (!update_done && n < 60) begin @(negedge clk); n++; end
        if (!update_done) begin
            chk({name, " update timeout"}, 32'(update_done), 32'd1);
            return;
        end
        if (exp_lat > 0) chk({name, " latency"}, 32'(n), 32'(exp_lat));
        chk({name, " digit_out"}, digit_out, ed);
        chk({name, " digit_en"}, 32'(digit_en), 32'(ee));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        reset2 = 1'b0;
        @(negedge clk);
        chk("reset digit_out", digit_out, 32'h0);
        chk("reset digit_en", 32'(digit_en), 32'h01);
        chk("reset flags", {29'd0, update_done, busy, overrun}, 32'h0);

        // Decimal peak of 100, -1234, 567
        send(100); send(-1234); send(567);
        run_interval(1'b1, 18, 32'h0000_1234, 8'h0F, "dec1234");
        chk("model dec1234", m_shown, 32'h0000_1234);
`ifdef SEG_LAMP_TEST_EN
        @(posedge clk); #1; lamp_test = 1'b1;
        @(negedge clk);
        chk("lamp digit_out", digit_out, 32'h8888_8888);
        chk("lamp digit_en", 32'(digit_en), 32'hFF);
        @(posedge clk); #1; lamp_test = 1'b0;
        @(negedge clk);
        chk("lamp release", digit_out, 32'h0000_1234);
`endif
        run_interval(1'b1, 18, 32'h0, 8'h01, "dec0");

        send(-32768); send(32767);
        run_interval(1'b1, 18, 32'h0003_2768, 8'h1F, "dec32768");
        chk("model dec32768", {24'd0, m_shown_en}, 32'h1F);

        @(posedge clk); #1; mode = 1'b1;
        send(-2);
        run_interval(1'b1, 2, 32'h0000_FFFE, 8'h0F, "hexFFFE");
        chk("model hexFFFE", m_shown, 32'h0000_FFFE);

        // Sample coincident with the capture cycle goes to the next interval
        @(posedge clk); #1; mode = 1'b0;
        send(50);
        n = 0;
        @(posedge clk); #1;
        while (m_cnt != R - 1 && n < 300) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        sample_valid = 1'b1; sample_in = W'(9000);
        @(posedge clk); #1;
        sample_valid = 1'b0;
        run_interval(1'b0, 0, 32'h0000_0050, 8'h03, "dec50");
        run_interval(1'b1, 18, 32'h0000_9000, 8'h0F, "dec9000");

        // Randomized traffic, mode toggling freely
        for (int i = 0; i < 700; i++) begin
            @(posedge clk); #1;
            sample_valid = ($urandom_range(0, 2) == 0);
            sample_in    = W'($urandom);
            mode         = ($urandom_range(0, 3) == 0);
        end
        sample_valid = 1'b0;
        mode = 1'b0;

        // Reset during the 7th conversion cycle
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin @(negedge clk); n++; end
        send(4321);
        n = 0;
        @(negedge clk);
        while (!busy && n < 300) begin @(negedge clk); n++; end
        chk("pre-abort busy", 32'(busy), 32'd1);
        repeat (7) @(posedge clk);
        #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        chk("abort digit_out", digit_out, 32'h0);
        chk("abort digit_en", 32'(digit_en), 32'h01);
        chk("abort flags", {29'd0, update_done, busy, overrun}, 32'h0);
        send(777);
        run_interval(1'b1, 18, 32'h0000_0777, 8'h07, "dec777");

        // Overrun instance
        chk("ovr2 first rise", 32'(first_ovr2), 32'd20);
        chk("ovr2 first done", 32'(first_done2), 32'd27);
        chk("ovr2 sticky", 32'(overrun2), 32'd1);
        chk("ovr2 done count", 32'(done2 >= 3), 32'd1);
        chk("ovr2 digit_out", digit_out2, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
